inst_mem: RTL and testbench

Instruction memory responding to the core's fetch port (`rom_ce`/`rom_addr`/`rom_data`). It answers fetches combinationally, so the fetch word is captured by `if_id` in the same cycle the PC is presented. A byte-serial programming port loads program images at run time. Incoming bytes are assembled big-endian into words and committed through a small loader state machine.

---
 rtl/inst_mem_pkg.sv | 34 +++
 rtl/inst_mem_loader.sv | 168 ++++++++++++++++
 rtl/inst_mem.sv | 70 +++++++
 tb/tb_inst_mem.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared constants and helpers for the instruction memory and its loader.
// Optional checksum feature: INST_MEM_CKSUM_EN (see inst_mem_loader).
package inst_mem_pkg;

  // Default word-address width: 2^10 instruction words.
  localparam int INST_MEM_NUM_LOG2 = 10;

  // Instruction bus and programming byte widths.
  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [INST_W-1:0] ZERO_WORD   = '0;
  localparam logic              CHIP_ENABLE = 1'b1;

  // Drop a byte into the assembly word at byte lane 'lane', counting from the
  // MSB. The first byte of a word lands in [31:24]. Lanes that are never
  // written stay zero, which gives the zero padding of a short final word.
  function automatic logic [INST_W-1:0] place_byte(
    input logic [INST_W-1:0] w,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] b
  );
    logic [INST_W-1:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Byte-serial program loader: assembles big-endian words from a byte stream
// and commits each word into the instruction memory through one write port.
// FSM: IDLE -> LOAD <-> COMMIT. Start always wins and discards a partial word.
// Optional feature macro INST_MEM_CKSUM_EN: running mod-2^32 sum of committed
// words; without it prog_cksum_o is tied to zero and no adder is built.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = INST_MEM_NUM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_start_i,
  input  logic [INST_W-1:0] prog_base_i,
  input  logic              prog_valid_i,
  input  logic [BYTE_W-1:0] prog_byte_i,
  output logic              prog_ready_o,
  input  logic              prog_end_i,
  output logic              prog_busy_o,
  output logic [ADDR_W:0]   prog_words_o,
  output logic              prog_err_o,
  output logic [INST_W-1:0] prog_cksum_o,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [INST_W-1:0] wdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Word counter saturates at exactly 2^ADDR_W.
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q,   ptr_d;
  logic [2:0]          cnt_q,   cnt_d;
  logic [INST_W-1:0]   asm_q,   asm_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                err_q,   err_d;
  logic                pend_q,  pend_d;

  // Byte count / assembly word after this cycle's byte (if any) is taken.
  logic [2:0]          cnt_acc;
  logic [INST_W-1:0]   asm_acc;
  logic                commit;

  // Only the word-index bits of the base address matter.
  logic                unused_base;
  assign unused_base = ^{prog_base_i[INST_W-1:ADDR_W+2], prog_base_i[1:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath update: start first, then byte, then end.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    words_d = words_q;
    err_d   = err_q;
    pend_d  = pend_q;
    cnt_acc = cnt_q;
    asm_acc = asm_q;
    commit  = 1'b0;

    if (prog_start_i) begin
      // (Re)start from any state; a word sitting in COMMIT is dropped.
      state_d = ST_LOAD;
      ptr_d   = prog_base_i[ADDR_W+1:2];
      cnt_d   = 3'd0;
      asm_d   = ZERO_WORD;
      words_d = '0;
      err_d   = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // End pulses and stray bytes are ignored here.
        end

        ST_LOAD: begin
          if (prog_valid_i) begin
            asm_acc = place_byte(asm_q, cnt_q[1:0], prog_byte_i);
            cnt_acc = cnt_q + 3'd1;
          end
          asm_d = asm_acc;
          cnt_d = cnt_acc;
          if (cnt_acc == 3'd4) begin
            state_d = ST_COMMIT;
            pend_d  = prog_end_i;
          end else if (prog_end_i) begin
            if (cnt_acc == 3'd0) begin
              state_d = ST_IDLE;
            end else begin
              // Flush the zero-padded partial word, then stop.
              state_d = ST_COMMIT;
              pend_d  = 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          commit  = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          if (words_q != WORDS_MAX) words_d = words_q + (ADDR_W+1)'(1);
          if (ptr_q == {ADDR_W{1'b1}}) err_d = 1'b1;
          cnt_d   = 3'd0;
          asm_d   = ZERO_WORD;
          pend_d  = 1'b0;
          state_d = (pend_q || prog_end_i) ? ST_IDLE : ST_LOAD;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Loader datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= 3'd0;
      asm_q   <= ZERO_WORD;
      words_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      words_q <= words_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

`ifdef INST_MEM_CKSUM_EN
  logic [INST_W-1:0] cksum_q;

  // Running sum of committed words, cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cksum_q <= ZERO_WORD;
    else if (prog_start_i) cksum_q <= ZERO_WORD;
    else if (commit)       cksum_q <= cksum_q + asm_q;
  end

  assign prog_cksum_o = cksum_q;
`else
  assign prog_cksum_o = ZERO_WORD;
`endif

  assign prog_ready_o = (state_q == ST_LOAD);
  assign prog_busy_o  = (state_q != ST_IDLE);
  assign prog_words_o = words_q;
  assign prog_err_o   = err_q;

  assign we    = commit;
  assign waddr = ptr_q;
  assign wdata = asm_q;

endmodule

// File: rtl/inst_mem.sv
// Instruction memory: combinational fetch port for the core plus a
// byte-serial programming port handled by inst_mem_loader.
// Optional feature macro INST_MEM_CKSUM_EN enables the load checksum.
// The array itself is never reset, so programs survive rst.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = INST_MEM_NUM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [INST_W-1:0] rom_addr_i,
  output logic [INST_W-1:0] rom_data_o,
  input  logic              prog_start_i,
  input  logic [INST_W-1:0] prog_base_i,
  input  logic              prog_valid_i,
  input  logic [BYTE_W-1:0] prog_byte_i,
  output logic              prog_ready_o,
  input  logic              prog_end_i,
  output logic              prog_busy_o,
  output logic [ADDR_W:0]   prog_words_o,
  output logic              prog_err_o,
  output logic [INST_W-1:0] prog_cksum_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [INST_W-1:0] wdata;

  // Byte offset and out-of-range upper bits of the fetch address are ignored.
  logic              unused_addr;
  assign unused_addr = ^{rom_addr_i[INST_W-1:ADDR_W+2], rom_addr_i[1:0]};

  inst_mem_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .prog_start_i (prog_start_i),
    .prog_base_i  (prog_base_i),
    .prog_valid_i (prog_valid_i),
    .prog_byte_i  (prog_byte_i),
    .prog_ready_o (prog_ready_o),
    .prog_end_i   (prog_end_i),
    .prog_busy_o  (prog_busy_o),
    .prog_words_o (prog_words_o),
    .prog_err_o   (prog_err_o),
    .prog_cksum_o (prog_cksum_o),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata)
  );

  // Single write port; a fetch in the commit cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Zero-latency fetch, gated by chip enable and forced to zero in reset.
  always_comb begin
    rom_data_o = ZERO_WORD;
    if (!rst && (rom_ce_i == CHIP_ENABLE)) rom_data_o = mem[rom_addr_i[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: directed scenarios plus randomized loads
// checked against a byte-stream reference model of the loader.
module tb_inst_mem;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce_i = 1'b0;
  logic [31:0]   rom_addr_i = '0;
  logic [31:0]   rom_data_o;
  logic          prog_start_i = 1'b0;
  logic [31:0]   prog_base_i = '0;
  logic          prog_valid_i = 1'b0;
  logic [7:0]    prog_byte_i = '0;
  logic          prog_ready_o;
  logic          prog_end_i = 1'b0;
  logic          prog_busy_o;
  logic [AW:0]   prog_words_o;
  logic          prog_err_o;
  logic [31:0]   prog_cksum_o;

  int checks = 0;
  int errors = 0;

  inst_mem #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .prog_start_i (prog_start_i),
    .prog_base_i  (prog_base_i),
    .prog_valid_i (prog_valid_i),
    .prog_byte_i  (prog_byte_i),
    .prog_ready_o (prog_ready_o),
    .prog_end_i   (prog_end_i),
    .prog_busy_o  (prog_busy_o),
    .prog_words_o (prog_words_o),
    .prog_err_o   (prog_err_o),
    .prog_cksum_o (prog_cksum_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte stream -> words) ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_ptr;
  int          m_words;
  bit          m_err;
  logic [31:0] m_cksum;
  logic [7:0]  m_q[$];
  int          m_touched[$];

  function automatic void m_commit();
    logic [31:0] word;
    word = '0;
    for (int i = 0; i < m_q.size(); i++) word = word | (32'(m_q[i]) << (24 - 8 * i));
    m_mem[m_ptr] = word;
    m_wr[m_ptr]  = 1'b1;
    m_touched.push_back(m_ptr);
    if (m_ptr == DEPTH - 1) m_err = 1'b1;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_words < DEPTH) m_words++;
    m_cksum = m_cksum + word;
    m_q.delete();
  endfunction

  function automatic void m_start(input logic [31:0] base);
    m_q.delete();
    m_touched.delete();
    m_ptr   = int'((base >> 2) & 32'(DEPTH - 1));
    m_words = 0;
    m_err   = 1'b0;
    m_cksum = '0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    m_q.push_back(b);
    if (m_q.size() == 4) m_commit();
  endfunction

  function automatic void m_end();
    if (m_q.size() > 0) m_commit();
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_words = 0;
    m_err   = 1'b0;
    m_cksum = '0;
  endfunction

  function automatic logic [31:0] exp_cksum();
`ifdef INST_MEM_CKSUM_EN
    return m_cksum;
`else
    return 32'h0;
`endif
  endfunction

  // ---------------- drivers (entered and left at a falling edge) ----------
  task automatic pulse_start(input logic [31:0] base);
    prog_start_i = 1'b1;
    prog_base_i  = base;
    m_start(base);
    @(negedge clk);
    prog_start_i = 1'b0;
  endtask

  task automatic pulse_end();
    prog_end_i = 1'b1;
    m_end();
    @(negedge clk);
    prog_end_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit upd, input bit with_end);
    int n;
    n = 0;
    prog_valid_i = 1'b1;
    prog_byte_i  = b;
    while (!prog_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: ready=%0b after %0d cycles, expected 1", prog_ready_o, n);
    end
    if (with_end) prog_end_i = 1'b1;
    if (upd) begin
      m_byte(b);
      if (with_end) m_end();
    end
    @(negedge clk);
    prog_valid_i = 1'b0;
    prog_end_i   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (prog_busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (prog_busy_o) begin
      errors++;
      $display("FAIL wait_idle_timeout: busy=%0b after %0d cycles, expected 0", prog_busy_o, n);
    end
  endtask

  // Fetch word idx with random junk in the ignored address bits.
  task automatic rd(input int idx, output logic [31:0] d);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = idx[AW-1:0];
    rom_ce_i   = 1'b1;
    rom_addr_i = a;
    #1;
    d = rom_data_o;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h10;
    #1;
    checks++; if (prog_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", prog_busy_o); end
    checks++; if (prog_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", prog_ready_o); end
    checks++; if (prog_words_o !== '0) begin errors++; $display("FAIL reset_words: got %0d expected 0", prog_words_o); end
    checks++; if (prog_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", prog_err_o); end
    checks++; if (prog_cksum_o !== 32'h0) begin errors++; $display("FAIL reset_cksum: got %h expected 0", prog_cksum_o); end
    checks++; if (rom_data_o !== 32'h0) begin errors++; $display("FAIL reset_rom_data: got %h expected 0", rom_data_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0]  bs [8];
    logic [31:0] d;
    bs = '{8'h34, 8'h02, 8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pulse_start(32'h0000_0010);
    checks++; if (prog_busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %0b expected 1", prog_busy_o); end
    checks++; if (prog_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b expected 1", prog_ready_o); end
    for (int i = 0; i < 8; i++) send_byte(bs[i], 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    rd(4, d);
    checks++; if (d !== 32'h34020020) begin errors++; $display("FAIL basic_mem4: got %h expected 34020020", d); end
    rd(5, d);
    checks++; if (d !== 32'hAABBCCDD) begin errors++; $display("FAIL basic_mem5: got %h expected aabbccdd", d); end
    checks++; if (prog_words_o !== (AW+1)'(2)) begin errors++; $display("FAIL basic_words: got %0d expected 2", prog_words_o); end
    checks++; if (prog_cksum_o !== exp_cksum()) begin errors++; $display("FAIL basic_cksum: got %h expected %h", prog_cksum_o, exp_cksum()); end
  endtask

  task automatic test_partial();
    logic [31:0] d;
    pulse_start(32'h0);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    pulse_end();
    checks++; if (prog_busy_o !== 1'b1) begin errors++; $display("FAIL partial_busy_end1: got %0b expected 1", prog_busy_o); end
    @(negedge clk);
    checks++; if (prog_busy_o !== 1'b0) begin errors++; $display("FAIL partial_busy_end2: got %0b expected 0", prog_busy_o); end
    rd(0, d);
    checks++; if (d !== 32'h11220000) begin errors++; $display("FAIL partial_mem0: got %h expected 11220000", d); end
    checks++; if (prog_words_o !== (AW+1)'(1)) begin errors++; $display("FAIL partial_words: got %0d expected 1", prog_words_o); end
    checks++; if (prog_cksum_o !== exp_cksum()) begin errors++; $display("FAIL partial_cksum: got %h expected %h", prog_cksum_o, exp_cksum()); end
  endtask

  task automatic test_chip_enable();
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h10;
    #1;
    checks++; if (rom_data_o !== 32'h0) begin errors++; $display("FAIL ce_off: got %h expected 0", rom_data_o); end
    rom_ce_i = 1'b1;
    #1;
    checks++; if (rom_data_o !== 32'h34020020) begin errors++; $display("FAIL ce_on: got %h expected 34020020", rom_data_o); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    pulse_start(32'h5000_0FFF);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    checks++; if (prog_err_o !== 1'b0) begin errors++; $display("FAIL wrap_err_before: got %0b expected 0", prog_err_o); end
    @(negedge clk);
    checks++; if (prog_err_o !== 1'b1) begin errors++; $display("FAIL wrap_err_after: got %0b expected 1", prog_err_o); end
    checks++; if (prog_words_o !== (AW+1)'(1)) begin errors++; $display("FAIL wrap_words1: got %0d expected 1", prog_words_o); end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    checks++; if (prog_words_o !== (AW+1)'(2)) begin errors++; $display("FAIL wrap_words2: got %0d expected 2", prog_words_o); end
    checks++; if (prog_err_o !== 1'b1) begin errors++; $display("FAIL wrap_err_final: got %0b expected 1", prog_err_o); end
    rd(DEPTH - 1, d);
    checks++; if (d !== m_mem[DEPTH-1]) begin errors++; $display("FAIL wrap_mem_last: got %h expected %h", d, m_mem[DEPTH-1]); end
    rd(0, d);
    checks++; if (d !== m_mem[0]) begin errors++; $display("FAIL wrap_mem0: got %h expected %h", d, m_mem[0]); end
    checks++; if (prog_cksum_o !== exp_cksum()) begin errors++; $display("FAIL wrap_cksum: got %h expected %h", prog_cksum_o, exp_cksum()); end
  endtask

  task automatic test_restart();
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic [31:0] d;
    a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start(32'h30);
    for (int i = 0; i < 4; i++) send_byte(a[i], 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    pulse_start(32'h30);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    pulse_start(32'h20);
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    checks++; if (prog_words_o !== (AW+1)'(1)) begin errors++; $display("FAIL restart_words: got %0d expected 1", prog_words_o); end
    rd(8, d);
    checks++; if (d !== 32'h01020304) begin errors++; $display("FAIL restart_mem8: got %h expected 01020304", d); end
    rd(12, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL restart_mem12: got %h expected deadbeef", d); end
  endtask

  task automatic test_start_in_commit();
    logic [31:0] d;
    pulse_start(32'h40);
    for (int i = 0; i < 4; i++) send_byte(8'h5A, 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    pulse_start(32'h40);
    // Four bytes fill a word; the start lands in its commit cycle.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    pulse_start(32'h44);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    rd(16, d);
    checks++; if (d !== 32'h5A5A5A5A) begin errors++; $display("FAIL sic_mem16: got %h expected 5a5a5a5a", d); end
    rd(17, d);
    checks++; if (d !== m_mem[17]) begin errors++; $display("FAIL sic_mem17: got %h expected %h", d, m_mem[17]); end
    checks++; if (prog_words_o !== (AW+1)'(m_words)) begin errors++; $display("FAIL sic_words: got %0d expected %0d", prog_words_o, m_words); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, old;
    int nb;
    bit mode;
    // Write-to-read visibility around the commit edge.
    pulse_start(32'h50);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    old = m_mem[20];
    pulse_start(32'h50);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    rd(20, d);
    checks++; if (d !== old) begin errors++; $display("FAIL vis_during_commit: got %h expected %h", d, old); end
    rd(20, d);
    checks++; if (d !== m_mem[20]) begin errors++; $display("FAIL vis_after_commit: got %h expected %h", d, m_mem[20]); end
    pulse_end();
    wait_idle();
    // Randomized loads with gaps, partial words and end-with-byte.
    for (int r = 0; r < 24; r++) begin
      nb   = $urandom_range(0, 13);
      mode = 1'($urandom_range(0, 1));
      pulse_start($urandom);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_byte(8'($urandom), 1'b1, mode && (i == nb - 1));
      end
      if (!(mode && nb > 0)) pulse_end();
      wait_idle();
      checks++; if (prog_words_o !== (AW+1)'(m_words)) begin errors++; $display("FAIL rnd%0d_words: got %0d expected %0d", r, prog_words_o, m_words); end
      checks++; if (prog_err_o !== m_err) begin errors++; $display("FAIL rnd%0d_err: got %0b expected %0b", r, prog_err_o, m_err); end
      checks++; if (prog_cksum_o !== exp_cksum()) begin errors++; $display("FAIL rnd%0d_cksum: got %h expected %h", r, prog_cksum_o, exp_cksum()); end
      foreach (m_touched[k]) begin
        rd(m_touched[k], d);
        checks++; if (d !== m_mem[m_touched[k]]) begin errors++; $display("FAIL rnd%0d_mem%0d: got %h expected %h", r, m_touched[k], d, m_mem[m_touched[k]]); end
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    pulse_start(32'h0);
    for (int i = 0; i < 4 * (DEPTH + 1); i++) send_byte(8'($urandom), 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    checks++; if (prog_words_o !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL sat_words: got %0d expected %0d", prog_words_o, DEPTH); end
    checks++; if (prog_err_o !== 1'b1) begin errors++; $display("FAIL sat_err: got %0b expected 1", prog_err_o); end
    checks++; if (prog_cksum_o !== exp_cksum()) begin errors++; $display("FAIL sat_cksum: got %h expected %h", prog_cksum_o, exp_cksum()); end
    rd(0, d);
    checks++; if (d !== m_mem[0]) begin errors++; $display("FAIL sat_mem0: got %h expected %h", d, m_mem[0]); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    pulse_start(32'h60);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    pulse_end();
    wait_idle();
    pulse_start(32'h60);
    // Fill a word without telling the model; reset hits its commit cycle.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h60;
    #1 rst = 1'b1;
    m_reset();
    #1;
    checks++; if (prog_busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %0b expected 0", prog_busy_o); end
    checks++; if (prog_ready_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %0b expected 0", prog_ready_o); end
    checks++; if (prog_words_o !== '0) begin errors++; $display("FAIL arst_words: got %0d expected 0", prog_words_o); end
    checks++; if (prog_err_o !== 1'b0) begin errors++; $display("FAIL arst_err: got %0b expected 0", prog_err_o); end
    checks++; if (prog_cksum_o !== 32'h0) begin errors++; $display("FAIL arst_cksum: got %h expected 0", prog_cksum_o); end
    checks++; if (rom_data_o !== 32'h0) begin errors++; $display("FAIL arst_rom_data: got %h expected 0", rom_data_o); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (prog_busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy_after: got %0b expected 0", prog_busy_o); end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_wr[i]) begin
        rd(i, d);
        checks++; if (d !== m_mem[i]) begin errors++; $display("FAIL arst_keep_mem%0d: got %h expected %h", i, d, m_mem[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    m_start(32'h0);
    test_reset();
    test_basic();
    test_partial();
    test_chip_enable();
    test_wrap();
    test_restart();
    test_start_in_commit();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
